pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the five-stage pipeline. Decides every cycle whether the IF/ID registers hold and the ID/EX register is bubbled.
- Combines three stall sources:
  - Tuse/Tnew data-hazard stalls.
  - MDU busy stalls, from an internal mult/div cycle sequencer.
  - eret-versus-EPC-write stalls.
- Sits beside the stage registers and takes stage fields (RegDst, RegWrite, Tnew, CP0Write, Rd) from the E and M stages. The exception request Req overrides every stall.

---
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Merges operand (Tuse/Tnew) hazards, MDU busy hazards and eret-vs-EPC
// hazards into a single stall. This stall holds PC and IF/ID and bubbles ID/EX.
// An exception request overrides every stall. The block also contains the
// mult/div cycle sequencer and a free-running stall-cycle counter.
module pipe_hazard_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int CNT_W    = 4,
   parameter int EPC_REG  = 14
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic [4:0]  RsD,
   input  logic [4:0]  RtD,
   input  logic [1:0]  TuseRsD,
   input  logic [1:0]  TuseRtD,
   input  logic        MdUseD,
   input  logic        EretD,
   input  logic        RegWriteE,
   input  logic [4:0]  RegDstE,
   input  logic [1:0]  TnewE,
   input  logic        MdStartE,
   input  logic        MdTypeE,
   input  logic        CP0WriteE,
   input  logic [4:0]  RdE,
   input  logic        RegWriteM,
   input  logic [4:0]  RegDstM,
   input  logic [1:0]  TnewM,
   input  logic        CP0WriteM,
   input  logic [4:0]  RdM,
   output logic        StallF,
   output logic        StallD,
   output logic        FlushE,
   output logic        MdBusy,
   output logic        MdDone,
   output logic [31:0] StallCnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2
   } md_state_t;

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [4:0]       EPC_NUM   = 5'(EPC_REG);

   md_state_t        state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             md_done_reg, md_done_next;
   logic [31:0]      stall_cnt_reg;

   // Operand 0 is rs, operand 1 is rt; both follow the same forwarding-limit rule.
   logic [1:0][4:0] src_reg;
   logic [1:0][1:0] src_tuse;
   logic [1:0]      hz_op;

   logic md_start_ok;
   logic hz_md;
   logic hz_eret;
   logic stall_raw;
   logic stall_out;

   assign src_reg[0]  = RsD;
   assign src_reg[1]  = RtD;
   assign src_tuse[0] = TuseRsD;
   assign src_tuse[1] = TuseRtD;

   // A producer stalls the reader only when its result arrives later than the
   // reader needs it. $0 is never a real dependency, and Tuse 3 means unread.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_opnd
         logic hit_e;
         logic hit_m;
         assign hit_e = RegWriteE & (RegDstE == src_reg[gi]) & (TnewE > src_tuse[gi]);
         assign hit_m = RegWriteM & (RegDstM == src_reg[gi]) & (TnewM > src_tuse[gi]);
         assign hz_op[gi] = (src_reg[gi] != 5'd0) & (src_tuse[gi] != 2'd3) & (hit_e | hit_m);
      end
   endgenerate

   // A start in E launches the MDU unless the E instruction is being killed.
   assign md_start_ok = MdStartE & ~Req;

   // Any HI/LO user in D waits while the MDU is starting or still running.
   assign hz_md = MdUseD & (MdStartE | (state_reg != IDLE));

   // eret must not read EPC while an mtc0 to EPC is still in flight.
   assign hz_eret = EretD & ((CP0WriteE & (RdE == EPC_NUM)) |
                             (CP0WriteM & (RdM == EPC_NUM)));

   assign stall_raw = hz_op[0] | hz_op[1] | hz_md | hz_eret;

   // The exception flush wins: the stage registers clear themselves, so
   // holding them would only stall the jump to the handler.
   assign stall_out = stall_raw & ~Req & ~reset;

   assign StallF   = stall_out;
   assign StallD   = stall_out;
   assign FlushE   = stall_out;
   assign MdBusy   = ((state_reg != IDLE) | md_start_ok) & ~reset;
   assign MdDone   = md_done_reg;
   assign StallCnt = stall_cnt_reg;

   // MDU sequencer next-state: load the latency on start, then count down.
   // The done pulse is timed for the edge that returns the FSM to IDLE.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      md_done_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (md_start_ok) begin
               if (MdTypeE) begin
                  state_next = DIV;
                  cnt_next   = DIV_LOAD;
               end else begin
                  state_next = MULT;
                  cnt_next   = MULT_LOAD;
               end
            end
         end
         MULT, DIV: begin
            // A running op belongs to a committed instruction, so Req does
            // not abort it. A second start here is ignored.
            if (cnt_reg == CNT_ONE) begin
               state_next   = IDLE;
               cnt_next     = '0;
               md_done_next = 1'b1;
            end else if (cnt_reg == '0) begin
               // Unreachable count; recover to IDLE instead of wrapping.
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg - CNT_ONE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // MDU sequencer state, counter and registered done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         md_done_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         md_done_reg <= md_done_next;
      end
   end

   // Count cycles spent stalled. Coincident hazards still count once, and
   // the counter wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_reg <= '0;
      end else if (stall_out) begin
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl.
// Each cycle, the expected observation is built from the bench's own stimulus
// and its MDU latency model, then queued. It is popped and compared at the
// falling edge.
module tb_pipe_hazard_ctrl;

   logic        clk;
   logic        reset;
   logic        Req;
   logic [4:0]  RsD, RtD;
   logic [1:0]  TuseRsD, TuseRtD;
   logic        MdUseD, EretD;
   logic        RegWriteE;
   logic [4:0]  RegDstE;
   logic [1:0]  TnewE;
   logic        MdStartE, MdTypeE, CP0WriteE;
   logic [4:0]  RdE;
   logic        RegWriteM;
   logic [4:0]  RegDstM;
   logic [1:0]  TnewM;
   logic        CP0WriteM;
   logic [4:0]  RdM;
   logic        StallF, StallD, FlushE, MdBusy, MdDone;
   logic [31:0] StallCnt;

   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset), .Req(Req),
      .RsD(RsD), .RtD(RtD), .TuseRsD(TuseRsD), .TuseRtD(TuseRtD),
      .MdUseD(MdUseD), .EretD(EretD),
      .RegWriteE(RegWriteE), .RegDstE(RegDstE), .TnewE(TnewE),
      .MdStartE(MdStartE), .MdTypeE(MdTypeE), .CP0WriteE(CP0WriteE), .RdE(RdE),
      .RegWriteM(RegWriteM), .RegDstM(RegDstM), .TnewM(TnewM),
      .CP0WriteM(CP0WriteM), .RdM(RdM),
      .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
      .MdBusy(MdBusy), .MdDone(MdDone), .StallCnt(StallCnt)
   );

   typedef struct packed {
      logic        stallf;
      logic        stalld;
      logic        flushe;
      logic        busy;
      logic        done;
      logic [31:0] cnt;
   } obs_t;

   typedef struct {
      logic [4:0] rs;  logic [4:0] rt;
      logic [1:0] urs; logic [1:0] urt;
      logic we_e; logic [4:0] de; logic [1:0] te;
      logic we_m; logic [4:0] dm; logic [1:0] tm;
      logic exp;
   } dh_t;

   obs_t        exp_q[$];
   obs_t        e, got;
   dh_t         tbl[10];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_cnt;
   int          m_left;
   logic        m_done;
   logic        cur_stall;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_inputs();
      Req = 0; RsD = 0; RtD = 0; TuseRsD = 3; TuseRtD = 3;
      MdUseD = 0; EretD = 0;
      RegWriteE = 0; RegDstE = 0; TnewE = 0;
      MdStartE = 0; MdTypeE = 0; CP0WriteE = 0; RdE = 0;
      RegWriteM = 0; RegDstM = 0; TnewM = 0; CP0WriteM = 0; RdM = 0;
   endtask

   task automatic model_reset();
      model_cnt = 0; m_left = 0; m_done = 0; cur_stall = 0;
   endtask

   // Queue the observation expected in the current cycle.
   task automatic push_exp(input logic stall);
      obs_t x;
      x.stallf = stall; x.stalld = stall; x.flushe = stall;
      x.busy   = (m_left != 0) || (MdStartE && !Req);
      x.done   = m_done;
      x.cnt    = model_cnt;
      exp_q.push_back(x);
      cur_stall = stall;
   endtask

   // Advance one clock and update the bench's own latency/counter model.
   task automatic end_cycle();
      @(posedge clk);
      if (cur_stall) model_cnt = model_cnt + 1;
      if (m_left == 0) begin
         m_done = 0;
         if (MdStartE && !Req) m_left = MdTypeE ? 10 : 5;
      end else if (m_left == 1) begin
         m_left = 0; m_done = 1;
      end else begin
         m_left = m_left - 1; m_done = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1;
      clear_inputs();
      RsD = 1; TuseRsD = 1; RegWriteE = 1; RegDstE = 1; TnewE = 2;
      MdStartE = 1; MdUseD = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         got = {StallF, StallD, FlushE, MdBusy, MdDone, StallCnt};
         checks++;
         if (got !== '0) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got %h expected 0", i, got);
         end
      end
      clear_inputs();
      @(posedge clk); #1;
      reset = 0;
      model_reset();
      push_exp(0);
      @(negedge clk);
      e = exp_q.pop_front();
      got = {StallF, StallD, FlushE, MdBusy, MdDone, StallCnt};
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL reset_release: got %h expected %h", got, e);
      end
      end_cycle();
      $display("test_reset done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_data_hazard();
      //           rs rt urs urt weE dE tE weM dM tM exp
      tbl[0] = '{1, 0, 1, 3, 1, 1, 2, 0, 0, 0, 1};  // lw in E, use next: stall
      tbl[1] = '{1, 0, 1, 3, 1, 1, 1, 0, 0, 0, 0};  // Tnew 1 not > Tuse 1
      tbl[2] = '{0, 0, 0, 3, 1, 0, 3, 0, 0, 0, 0};  // $0 never stalls
      tbl[3] = '{0, 5, 3, 0, 0, 0, 0, 1, 5, 1, 1};  // rt vs M producer
      tbl[4] = '{0, 5, 3, 3, 0, 0, 0, 1, 5, 3, 0};  // rt unused
      tbl[5] = '{1, 0, 0, 3, 0, 1, 2, 0, 0, 0, 0};  // E does not write
      tbl[6] = '{7, 7, 0, 0, 1, 7, 2, 1, 7, 1, 1};  // both operands: one stall
      tbl[7] = '{1, 0, 2, 3, 1, 1, 2, 0, 0, 0, 0};  // Tnew == Tuse: forward
      tbl[8] = '{1, 0, 0, 3, 1, 2, 2, 0, 0, 0, 0};  // different register
      tbl[9] = '{3, 0, 0, 3, 0, 0, 0, 1, 3, 1, 1};  // rs vs M producer
      for (int i = 0; i < 10; i++) begin
         clear_inputs();
         RsD = tbl[i].rs; RtD = tbl[i].rt; TuseRsD = tbl[i].urs; TuseRtD = tbl[i].urt;
         RegWriteE = tbl[i].we_e; RegDstE = tbl[i].de; TnewE = tbl[i].te;
         RegWriteM = tbl[i].we_m; RegDstM = tbl[i].dm; TnewM = tbl[i].tm;
         push_exp(tbl[i].exp);
         @(negedge clk);
         e = exp_q.pop_front();
         got = {StallF, StallD, FlushE, MdBusy, MdDone, StallCnt};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL data_hazard[%0d]: got %h expected %h", i, got, e);
         end
         end_cycle();
      end
      $display("test_data_hazard done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_eret();
      for (int i = 0; i < 5; i++) begin
         logic s;
         clear_inputs();
         EretD = 1;
         case (i)
            0: begin CP0WriteM = 1; RdM = 14; s = 1; end
            1: begin CP0WriteM = 1; RdM = 12; s = 0; end
            2: begin CP0WriteE = 1; RdE = 14; s = 1; end
            3: begin CP0WriteE = 0; RdE = 14; s = 0; end
            default: begin EretD = 0; CP0WriteM = 1; RdM = 14; s = 0; end
         endcase
         push_exp(s);
         @(negedge clk);
         e = exp_q.pop_front();
         got = {StallF, StallD, FlushE, MdBusy, MdDone, StallCnt};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL eret[%0d]: got %h expected %h", i, got, e);
         end
         end_cycle();
      end
      $display("test_eret done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_req_override();
      for (int i = 0; i < 3; i++) begin
         clear_inputs();
         Req = 1;
         case (i)
            0: begin RsD = 1; TuseRsD = 0; RegWriteE = 1; RegDstE = 1; TnewE = 2; end
            1: begin EretD = 1; CP0WriteM = 1; RdM = 14; end
            default: begin MdUseD = 1; MdStartE = 1; MdTypeE = 1; end
         endcase
         push_exp(0);
         @(negedge clk);
         e = exp_q.pop_front();
         got = {StallF, StallD, FlushE, MdBusy, MdDone, StallCnt};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL req_override[%0d]: got %h expected %h", i, got, e);
         end
         end_cycle();
      end
      $display("test_req_override done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_mult();
      // Start cycle, five busy cycles with mflo waiting in D, then the
      // mflo proceeds while MdDone pulses. A stray start mid-op is ignored.
      for (int i = 0; i < 9; i++) begin
         logic s;
         clear_inputs();
         if (i == 0) begin
            MdStartE = 1; MdTypeE = 0; s = 0;
         end else if (i <= 5) begin
            MdUseD = 1; s = 1;
            if (i == 2) begin MdStartE = 1; MdTypeE = 1; end
         end else if (i == 6) begin
            MdUseD = 1; s = 0;
         end else begin
            s = 0;
         end
         push_exp(s);
         @(negedge clk);
         e = exp_q.pop_front();
         got = {StallF, StallD, FlushE, MdBusy, MdDone, StallCnt};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL mult[%0d]: got %h expected %h", i, got, e);
         end
         end_cycle();
      end
      $display("test_mult done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_div_req();
      // A killed start never launches the divider.
      for (int i = 0; i < 12; i++) begin
         clear_inputs();
         if (i == 0) begin MdStartE = 1; MdTypeE = 1; Req = 1; end
         push_exp(0);
         @(negedge clk);
         e = exp_q.pop_front();
         got = {StallF, StallD, FlushE, MdBusy, MdDone, StallCnt};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL div_killed[%0d]: got %h expected %h", i, got, e);
         end
         end_cycle();
      end
      // A later Req does not abort a running divide.
      for (int i = 0; i < 14; i++) begin
         clear_inputs();
         if (i == 0) begin MdStartE = 1; MdTypeE = 1; end
         if (i == 3) Req = 1;
         push_exp(0);
         @(negedge clk);
         e = exp_q.pop_front();
         got = {StallF, StallD, FlushE, MdBusy, MdDone, StallCnt};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL div_req_late[%0d]: got %h expected %h", i, got, e);
         end
         end_cycle();
      end
      $display("test_div_req done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_stallcnt_reset();
      clear_inputs();
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      model_reset();
      // Start a divide, then hold an MDU user in D for seven stall cycles.
      for (int i = 0; i < 8; i++) begin
         clear_inputs();
         if (i == 0) begin MdStartE = 1; MdTypeE = 1; end
         else MdUseD = 1;
         push_exp(i != 0);
         @(negedge clk);
         e = exp_q.pop_front();
         got = {StallF, StallD, FlushE, MdBusy, MdDone, StallCnt};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL stall_run[%0d]: got %h expected %h", i, got, e);
         end
         end_cycle();
      end
      checks++;
      if (StallCnt !== model_cnt || model_cnt != 7) begin
         errors++;
         $display("FAIL stallcnt_before_reset: got %0d expected 7", StallCnt);
      end
      // Asynchronous reset in the middle of the cycle and of the divide.
      reset = 1;
      #1;
      got = {StallF, StallD, FlushE, MdBusy, MdDone, StallCnt};
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL async_reset: got %h expected 0", got);
      end
      @(posedge clk); #1;
      reset = 0;
      model_reset();
      push_exp(0);
      @(negedge clk);
      e = exp_q.pop_front();
      got = {StallF, StallD, FlushE, MdBusy, MdDone, StallCnt};
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL idle_after_reset: got %h expected %h", got, e);
      end
      end_cycle();
      $display("test_stallcnt_reset done: checks=%0d errors=%0d", checks, errors);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_data_hazard();
      test_eret();
      test_req_override();
      test_mult();
      test_div_req();
      test_stallcnt_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
